// File: rtl/parameters_rounder_pipe_if.sv
// Stream bundle carrying packed fit-parameter words into and out of the rounder.
// The master side is the producer/consumer pair around the block; the slave side is the rounder itself.
interface parameters_rounder_pipe_if #(
  parameter int NFIELD = 3,
  parameter int WIN    = 14,
  parameter int DROP   = 1
);
  localparam int WOUT = WIN - DROP;

  logic                   in_valid;
  logic                   in_ready;
  logic [NFIELD*WIN-1:0]  in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [NFIELD*WOUT-1:0] out_data;
  logic [NFIELD-1:0]      out_sat;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/parameters_rounder_pipe.sv
// Two-stage rounder for packed fit-parameter words: each field loses DROP LSBs under a
// run-time rounding mode, saturating at the field maximum, with a count of saturated words.
module parameters_rounder_pipe #(
  parameter int                NFIELD      = 3,
  parameter int                WIN         = 14,
  parameter int                DROP        = 1,
  parameter logic [NFIELD-1:0] SIGNED_MASK = 3'b011,
  parameter int                CNT_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  parameters_rounder_pipe_if.slave bus,
  input  logic                    sat_clear,
  output logic [CNT_W-1:0]        sat_count
);
  localparam int WOUT = WIN - DROP;
  localparam logic [DROP:0] HALF = (DROP+1)'(1) << (DROP - 1);

  typedef enum logic [1:0] {
    TRUNC      = 2'd0,
    HALF_UP    = 2'd1,
    HALF_AWAY  = 2'd2,
    CONVERGENT = 2'd3
  } round_mode_e;

  logic                   en;
  logic                   in_fire;
  logic                   out_fire;
  logic                   s1_valid;
  logic [NFIELD*WIN-1:0]  s1_data;
  round_mode_e            s1_mode;
  logic                   out_valid_q;
  logic [NFIELD*WOUT-1:0] out_data_q;
  logic [NFIELD-1:0]      out_sat_q;
  logic [NFIELD*WOUT-1:0] rnd_data;
  logic [NFIELD-1:0]      rnd_sat;

  // Returns {saturated, rounded value}; the increment is at most 1, so only the top can overflow.
  function automatic logic [WOUT:0] round_field(input logic [WIN-1:0] v,
                                                input logic           is_signed,
                                                input round_mode_e    mode);
    logic [WOUT-1:0] quot;
    logic [DROP:0]   frac;
    logic            neg;
    logic            gt;
    logic            eq;
    logic            inc;
    logic            ovf;
    logic [WOUT:0]   sum;
    logic [WOUT-1:0] res;
    quot = v[WIN-1:DROP];
    frac = {1'b0, v[DROP-1:0]};
    neg  = is_signed & v[WIN-1];
    gt   = frac > HALF;
    eq   = frac == HALF;
    inc  = 1'b0;
    case (mode)
      TRUNC:      inc = 1'b0;
      HALF_UP:    inc = gt | eq;
      HALF_AWAY:  inc = neg ? gt : (gt | eq);
      CONVERGENT: inc = gt | (eq & quot[0]);
      default:    inc = 1'b0;
    endcase
    sum = {is_signed & quot[WOUT-1], quot} + {{WOUT{1'b0}}, inc};
    ovf = is_signed ? (sum[WOUT] ^ sum[WOUT-1]) : sum[WOUT];
    if (ovf) begin
      res = is_signed ? {1'b0, {(WOUT-1){1'b1}}} : {WOUT{1'b1}};
    end else begin
      res = sum[WOUT-1:0];
    end
    return {ovf, res};
  endfunction

  assign en           = !out_valid_q | bus.out_ready;
  assign in_fire      = bus.in_valid & en;
  assign out_fire     = out_valid_q & bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    rnd_data = '0;
    rnd_sat  = '0;
    for (int k = 0; k < NFIELD; k++) begin
      {rnd_sat[k], rnd_data[k*WOUT +: WOUT]} =
        round_field(s1_data[k*WIN +: WIN], SIGNED_MASK[k], s1_mode);
    end
  end

  // Both stages advance together; the output register keeps its last word when a bubble passes.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_mode     <= TRUNC;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else if (en) begin
      s1_valid    <= in_fire;
      out_valid_q <= s1_valid;
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_mode <= round_mode_e'(bus.in_mode);
      end
      if (s1_valid) begin
        out_data_q <= rnd_data;
        out_sat_q  <= rnd_sat;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || sat_clear) begin
      sat_count <= '0;
    end else if (out_fire && (|out_sat_q) && (sat_count != {CNT_W{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_parameters_rounder_pipe.sv
// Bench for parameters_rounder_pipe: directed spec cases plus random traffic,
// scored against an integer-arithmetic rounding model and a queue of expected words.
module tb_parameters_rounder_pipe;
  localparam int         NFIELD = 3;
  localparam int         WIN    = 14;
  localparam int         DROP   = 1;
  localparam int         WOUT   = WIN - DROP;
  localparam int         CNT_W  = 16;
  localparam logic [2:0] SMASK  = 3'b011;

  typedef struct {
    logic [NFIELD*WOUT-1:0] d;
    logic [NFIELD-1:0]      s;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             sat_clear;
  logic [CNT_W-1:0] sat_count;
  int               checks = 0;
  int               errors = 0;
  int               exp_cnt = 0;
  logic             last_fire_in;
  exp_t             sb[$];

  parameters_rounder_pipe_if #(.NFIELD(NFIELD), .WIN(WIN), .DROP(DROP)) bus();

  parameters_rounder_pipe #(
    .NFIELD(NFIELD), .WIN(WIN), .DROP(DROP), .SIGNED_MASK(SMASK), .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference rounding: real integer values, floor division, then the mode's tie rule.
  function automatic exp_t model_word(input logic [NFIELD*WIN-1:0] d, input logic [1:0] m);
    exp_t           e;
    logic [WIN-1:0] raw;
    int             v, f, q, r, maxv, scale, half;
    scale = 1 << DROP;
    half  = scale / 2;
    e.d   = '0;
    e.s   = '0;
    for (int k = 0; k < NFIELD; k++) begin
      raw = d[k*WIN +: WIN];
      v   = SMASK[k] ? int'($signed(raw)) : int'(raw);
      f   = ((v % scale) + scale) % scale;
      q   = (v - f) / scale;
      case (m)
        2'd0:    r = q;
        2'd1:    r = q + ((f >= half) ? 1 : 0);
        2'd2:    r = (v < 0) ? q + ((f > half) ? 1 : 0) : q + ((f >= half) ? 1 : 0);
        default: r = (f > half || (f == half && (q % 2) != 0)) ? q + 1 : q;
      endcase
      maxv = SMASK[k] ? (1 << (WOUT-1)) - 1 : (1 << WOUT) - 1;
      if (r > maxv) begin
        r      = maxv;
        e.s[k] = 1'b1;
      end
      e.d[k*WOUT +: WOUT] = r[WOUT-1:0];
    end
    return e;
  endfunction

  function automatic logic [NFIELD*WIN-1:0] rand_word();
    logic [NFIELD*WIN-1:0] w;
    logic [WIN-1:0]        fld;
    w = '0;
    for (int k = 0; k < NFIELD; k++) begin
      case ($urandom_range(0, 5))
        0:       fld = 14'h1FFF;
        1:       fld = 14'h2000;
        2:       fld = 14'h3FFF;
        3:       fld = 14'h1FFE;
        default: fld = 14'($urandom);
      endcase
      w[k*WIN +: WIN] = fld;
    end
    return w;
  endfunction

  function automatic int field_val(input int k);
    logic [WOUT-1:0] raw;
    raw = bus.out_data[k*WOUT +: WOUT];
    return SMASK[k] ? int'($signed(raw)) : int'(raw);
  endfunction

  // One clock: score handshakes just before the edge, then check stall stability and the counter.
  task automatic tick();
    exp_t                   e;
    logic                   fire_in, fire_out, stalled, rst_now;
    logic [NFIELD*WOUT-1:0] hold_d;
    logic [NFIELD-1:0]      hold_s;
    #1;
    rst_now  = reset;
    fire_in  = bus.in_valid & bus.in_ready;
    fire_out = bus.out_valid & bus.out_ready;
    stalled  = bus.out_valid & !bus.out_ready;
    hold_d   = bus.out_data;
    hold_s   = bus.out_sat;
    last_fire_in = fire_in & !rst_now;
    if (rst_now) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      if (stalled) checkOutput("in_ready_stall", 64'(bus.in_ready), 64'd0);
      if (fire_out) begin
        checkOutput("sb_has_word", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("out_data", 64'(bus.out_data), 64'(e.d));
          checkOutput("out_sat", 64'(bus.out_sat), 64'(e.s));
          if (e.s != 0 && exp_cnt < 65535) exp_cnt++;
        end
      end
      if (sat_clear) exp_cnt = 0;
      if (fire_in) sb.push_back(model_word(bus.in_data, bus.in_mode));
    end
    @(posedge clock);
    #1;
    if (stalled && !rst_now) begin
      checkOutput("stall_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("stall_data", 64'(bus.out_data), 64'(hold_d));
      checkOutput("stall_sat", 64'(bus.out_sat), 64'(hold_s));
    end
    checkOutput("sat_count", 64'(sat_count), 64'(exp_cnt));
  endtask

  // Accepts one word; afterwards it sits in the output register with out_valid high.
  task automatic applyStimulus(input int f0, input int f1, input int f2, input logic [1:0] mode);
    bus.in_valid = 1'b1;
    bus.in_data  = {WIN'(f2), WIN'(f1), WIN'(f0)};
    bus.in_mode  = mode;
    tick();
    bus.in_valid = 1'b0;
    tick();
  endtask

  int         vals[9]  = '{5, 5, 5, 5, 7, -5, -5, -5, -5};
  logic [1:0] modes[9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  int         exps[9]  = '{2, 3, 3, 2, 4, -3, -2, -3, -2};
  int         sent;

  initial begin
    reset         = 1'b1;
    sat_clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_out_sat", 64'(bus.out_sat), 64'd0);
    checkOutput("rst_sat_count", 64'(sat_count), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);

    $display("[TB] rounding modes on field 0");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vals[i], 0, 0, modes[i]);
      checkOutput($sformatf("mode%0d_v%0d_valid", modes[i], vals[i]), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("mode%0d_v%0d", modes[i], vals[i]), 64'(field_val(0)), 64'(exps[i]));
    end

    $display("[TB] saturation");
    applyStimulus(8191, 0, 0, 2'd1);
    checkOutput("sat_f0_val", 64'(field_val(0)), 64'd4095);
    checkOutput("sat_f0_flag", 64'(bus.out_sat), 64'd1);
    tick();
    checkOutput("sat_f0_count", 64'(sat_count), 64'd1);
    applyStimulus(0, 0, 16383, 2'd1);
    checkOutput("sat_f2_val", 64'(field_val(2)), 64'd8191);
    checkOutput("sat_f2_flag", 64'(bus.out_sat), 64'd4);
    applyStimulus(-8192, 0, 0, 2'd1);
    checkOutput("min_f0_val", 64'(field_val(0)), 64'(-4096));
    checkOutput("min_f0_flag", 64'(bus.out_sat), 64'd0);
    tick();

    $display("[TB] latency");
    bus.in_valid = 1'b1;
    bus.in_data  = rand_word();
    bus.in_mode  = 2'($urandom);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("lat_edge_n", 64'(bus.out_valid), 64'd0);
    tick();
    checkOutput("lat_edge_n1", 64'(bus.out_valid), 64'd1);
    tick();
    checkOutput("lat_edge_n2", 64'(bus.out_valid), 64'd0);

    $display("[TB] backpressure");
    sent = 0;
    for (int c = 0; c < 40 && (sent < 6 || sb.size() != 0 || bus.out_valid); c++) begin
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid  = (sent < 6);
      bus.in_data   = rand_word();
      bus.in_mode   = 2'($urandom);
      tick();
      if (last_fire_in) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("bp_sent", 64'(sent), 64'd6);
    checkOutput("bp_drained", 64'(sb.size()), 64'd0);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = rand_word();
      bus.in_mode   = 2'($urandom);
      sat_clear     = ($urandom_range(0, 49) == 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    sat_clear     = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    checkOutput("rand_drained", 64'(sb.size()), 64'd0);

    $display("[TB] counter saturation");
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65539; i++) begin
      bus.in_data = {14'($urandom), 14'($urandom), 14'h1FFF};
      bus.in_mode = 2'($urandom_range(1, 3));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    tick();
    checkOutput("cnt_full", 64'(sat_count), 64'd65535);
    applyStimulus(8191, 0, 0, 2'd1);
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    checkOutput("cnt_clear_prio", 64'(sat_count), 64'd0);

    $display("[TB] reset mid-stream");
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = {14'd0, 14'd0, 14'h1FFF};
      bus.in_mode = 2'd1;
      tick();
    end
    checkOutput("pre_rst_cnt", 64'(sat_count != 0), 64'd1);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_cnt", 64'(sat_count), 64'd0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
